// File: rtl/up_down_mod_counter_if.sv
// Control/data bundle for the modulo-N up/down digit counter.
// The master drives the control and load inputs, and the slave returns the registered count.
interface up_down_mod_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             upDown;
  logic             ld;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] count;

  modport master (output en, output upDown, output ld, output in, input count);
  modport slave  (input en, input upDown, input ld, input in, output count);
endinterface

// File: rtl/up_down_mod_counter.sv
// Modulo-MOD up/down counter with enable and parallel load, used for alarm-clock digits.
// The count stays within 0..MOD-1, and loads that are out of range clear the count to 0.
module up_down_mod_counter #(
  parameter int WIDTH = 3,
  parameter int MOD   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  up_down_mod_counter_if.slave  bus
);

  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("up_down_mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // One extra bit so that MOD == 2**WIDTH is representable for the range check.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] count_q;
  logic             in_ok;

  assign in_ok = ({1'b0, bus.in} < MOD_EXT);

  // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (bus.ld) begin
      count_q <= in_ok ? bus.in : '0;
    end else if (bus.en) begin
      if (!bus.upDown) begin
        count_q <= (count_q == MAX_VAL) ? '0 : count_q + ONE;
      end else begin
        count_q <= (count_q == '0) ? MAX_VAL : count_q - ONE;
      end
    end
  end

  assign bus.count = count_q;

endmodule

// File: tb/tb_up_down_mod_counter.sv
// Self-checking bench for up_down_mod_counter (WIDTH=3, MOD=6): directed plan plus random traffic.
// A modulo-arithmetic reference model is compared every cycle, and literal expectations pin the model.
module tb_up_down_mod_counter;

  localparam int WIDTH = 3;
  localparam int MOD   = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   model    = 0;

  up_down_mod_counter_if #(.WIDTH(WIDTH)) bus ();

  up_down_mod_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: count=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load clamps to 0 when out of range, and a step is plain modulo-MOD arithmetic.
  always @(posedge clk or posedge rst) begin
    if (rst) model = 0;
    else if (bus.ld) model = (int'(bus.in) < MOD) ? int'(bus.in) : 0;
    else if (bus.en) model = bus.upDown ? (model + MOD - 1) % MOD : (model + 1) % MOD;
  end

  always @(negedge clk) check("model", int'(bus.count), model);

  task automatic expect_next(input string name, input int v);
    @(negedge clk);
    check(name, int'(bus.count), v);
  endtask

  int up_exp[7]   = '{1, 2, 3, 4, 5, 0, 1};
  int dn_exp[5]   = '{1, 0, 5, 4, 3};
  int oor_in[6]   = '{5, 7, 5, 6, 3, 0};
  int oor_exp[6]  = '{5, 0, 5, 0, 3, 0};

  initial begin
    bus.en = 1'b0; bus.upDown = 1'b0; bus.ld = 1'b0; bus.in = '0;
    rst = 1'b1;
    repeat (5) expect_next("reset_hold", 0);

    rst = 1'b0; bus.en = 1'b1;
    foreach (up_exp[i]) expect_next("count_up", up_exp[i]);

    bus.ld = 1'b1; bus.in = 3'd5;
    repeat (5) expect_next("load_en_high", 5);
    bus.ld = 1'b0;
    for (int v = 0; v < 4; v++) expect_next("after_load_up", v);

    bus.en = 1'b0;
    repeat (5) expect_next("hold", 3);
    bus.en = 1'b1;
    expect_next("resume", 4);

    bus.ld = 1'b1; bus.in = 3'd2;
    expect_next("load_2", 2);
    bus.ld = 1'b0; bus.upDown = 1'b1;
    foreach (dn_exp[i]) expect_next("count_down", dn_exp[i]);

    bus.en = 1'b0;
    foreach (oor_in[i]) begin
      bus.ld = 1'b1; bus.in = WIDTH'(oor_in[i]);
      expect_next("load_range", oor_exp[i]);
    end

    bus.in = 3'd4;
    expect_next("load_4", 4);
    bus.ld = 1'b0; bus.en = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset", int'(bus.count), 0);
    expect_next("reset_held", 0);
    rst = 1'b0; bus.en = 1'b1; bus.upDown = 1'b0;
    expect_next("post_reset_up", 1);

    // Random traffic: loads cover the full input range, and rare resets land mid-cycle.
    for (int c = 0; c < 600; c++) begin
      bus.en     = 1'($urandom_range(0, 3) != 0);
      bus.upDown = 1'($urandom_range(0, 1));
      bus.ld     = 1'($urandom_range(0, 7) == 0);
      bus.in     = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        #1 check("rand_async_reset", int'(bus.count), 0);
        #1 rst = 1'b0;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/up_down_mod_counter.md
# up_down_mod_counter

Parameterised synchronous modulo-N counter with direction control, count enable and parallel load. It sits in the alarm-clock digit datapath: a clock/alarm digit is preset via the load path and stepped up or down for time-setting. It holds a registered count in the range 0..MOD-1 and wraps at both ends.

## Interface

Clocking: one clock; reset is asynchronous and active-high (`clk`, `rst`).

Parameters:
- `WIDTH`, default 3: width of `in` and `count`.
- `MOD`, default 6: modulus; legal count values are 0..MOD-1. Requires 2 <= MOD <= 2^WIDTH.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset; forces `count` to 0.
- `en`  input  1  count enable; when high, steps `count` by one in the direction set by `upDown`.
- `upDown`  input  1  direction: 0 = count up, 1 = count down.
- `ld`  input  1  synchronous parallel load of `in`.
- `in`  input  WIDTH  load value.
- `count`  output  WIDTH  registered counter value.

## Operation

- Priority, highest first: `rst`, then `ld`, then `en`, then hold.
- `rst` = 1: `count` = 0 immediately, independent of `clk`. It stays 0 while `rst` is high.
- `ld` = 1 on a rising edge:
  - If `in` < MOD, `count` takes `in`.
  - If `in` >= MOD, `count` takes 0. Out-of-range values are never stored.
  - Load works whether `en` is high or low. `en` and `upDown` are ignored that cycle.
- `ld` = 0, `en` = 1, `upDown` = 0 (up):
  - `count` becomes `count`+1.
  - At MOD-1 it becomes 0 (wrap).
- `ld` = 0, `en` = 1, `upDown` = 1 (down):
  - `count` becomes `count`-1.
  - At 0 it becomes MOD-1 (wrap).
- `ld` = 0, `en` = 0: `count` holds.
- Arithmetic is modulo MOD in WIDTH bits. No intermediate value outside 0..MOD-1 is ever visible on `count`.
- `ld` held high for several cycles: reloads every cycle, so `count` stays at the loaded value and does not count.
- There is no terminal-count or carry output. A carry/borrow can be added later as a separate combinational output without changing `count` behaviour.

## Timing

- All non-reset updates occur on the rising edge of `clk`. There is one cycle of latency from input change to `count` change.
- `count` is driven directly from a register: glitch-free and no combinational path from inputs.
- Reset assertion is asynchronous. After deassertion, the first rising edge with `rst` = 0 applies normal priority.
- Reset mid-count or mid-load: `count` goes to 0 at once. Any pending load or step is discarded.
- A change of `upDown` takes effect on the next enabled edge. There is no turnaround cycle.

## Test plan

- Reset and count up, MOD=6: hold `rst` high 5 cycles, then `en`=1, `upDown`=0.
  - `count` = 0 during reset.
  - Then 1,2,3,4,5,0,1… on successive edges.
- Load with enable high: `ld`=1, `in`=5, `en`=1 for 5 cycles.
  - `count` = 5 from the first edge and stays 5 throughout.
  - After `ld`=0 with `upDown`=0: 0,1,2…
- Hold: `en`=0 at `count`=3 for 5 cycles.
  - `count` stays 3.
  - Re-enabling resumes from 3.
- Count down with wrap: load 2, then `en`=1, `upDown`=1.
  - `count` = 1,0,5,4,3…
- Out-of-range load: `ld`=1, `in`=7 with MOD=6 → `count` = 0.
  - Also check `in`=6 → 0.
  - Also check `in`=0 → 0.
- Asynchronous reset: assert `rst` between clock edges while `count`=4.
  - `count` = 0 before the next edge.
  - Release `rst` with `en`=1, `upDown`=0 → 1 on the first following edge.
